// File: rtl/alu_mul_sequencer.sv
// Multi-cycle shift-add multiply controller that drives the shared 32-bit EX-stage ALU.
// Define SIGNED_MUL_EN to add two's-complement support with fixed-latency abs/fix-up states.
module alu_mul_sequencer #(
    parameter int         WIDTH   = 32,
    parameter int         ITERS   = 32,
    parameter logic [3:0] CTL_ADD = 4'b0010,
    parameter logic [3:0] CTL_SUB = 4'b0110
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_data1,
    output logic [WIDTH-1:0] alu_data2,
    output logic [3:0]       alu_ctl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    localparam int CW = $clog2(ITERS);

`ifdef SIGNED_MUL_EN
    typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, RUN, FIX_LO, FIX_HI, DONE} state_t;
    logic negQ, negD, loNzQ, loNzD;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t           stateQ, stateD;
    logic [WIDTH-1:0] mQ, mD, hiQ, hiD, loQ, loD;
    logic [WIDTH-1:0] prodHiQ, prodHiD, prodLoQ, prodLoD;
    logic [CW-1:0]    cntQ, cntD;
    logic             carry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ  <= IDLE;
            mQ      <= '0;
            hiQ     <= '0;
            loQ     <= '0;
            cntQ    <= '0;
            prodHiQ <= '0;
            prodLoQ <= '0;
`ifdef SIGNED_MUL_EN
            negQ    <= 1'b0;
            loNzQ   <= 1'b0;
`endif
        end else begin
            stateQ  <= stateD;
            mQ      <= mD;
            hiQ     <= hiD;
            loQ     <= loD;
            cntQ    <= cntD;
            prodHiQ <= prodHiD;
            prodLoQ <= prodLoD;
`ifdef SIGNED_MUL_EN
            negQ    <= negD;
            loNzQ   <= loNzD;
`endif
        end
    end

    // The ALU result is only 32 bits; an unsigned wrap below hi recovers the 33rd sum bit.
    assign carry = (alu_result < hiQ);

    always_comb begin
        stateD    = stateQ;
        mD        = mQ;
        hiD       = hiQ;
        loD       = loQ;
        cntD      = cntQ;
        prodHiD   = prodHiQ;
        prodLoD   = prodLoQ;
        alu_data1 = '0;
        alu_data2 = '0;
        alu_ctl   = CTL_ADD;
`ifdef SIGNED_MUL_EN
        negD      = negQ;
        loNzD     = loNzQ;
`endif
        case (stateQ)
            IDLE: begin
                if (start) begin
                    mD   = mcand;
                    hiD  = '0;
                    loD  = mplier;
                    cntD = '0;
`ifdef SIGNED_MUL_EN
                    negD   = mcand[WIDTH-1] ^ mplier[WIDTH-1];
                    stateD = ABS_A;
`else
                    stateD = RUN;
`endif
                end
            end
`ifdef SIGNED_MUL_EN
            ABS_A: begin
                alu_data2 = mQ;
                alu_ctl   = mQ[WIDTH-1] ? CTL_SUB : CTL_ADD;
                mD        = alu_result;
                stateD    = ABS_B;
            end
            ABS_B: begin
                alu_data2 = loQ;
                alu_ctl   = loQ[WIDTH-1] ? CTL_SUB : CTL_ADD;
                loD       = alu_result;
                stateD    = RUN;
            end
`endif
            RUN: begin
                alu_data1 = hiQ;
                alu_data2 = loQ[0] ? mQ : '0;
                hiD       = {carry, alu_result[WIDTH-1:1]};
                loD       = {alu_result[0], loQ[WIDTH-1:1]};
                cntD      = cntQ + 1'b1;
                if (cntQ == CW'(ITERS - 1)) begin
`ifdef SIGNED_MUL_EN
                    stateD  = FIX_LO;
`else
                    prodHiD = {carry, alu_result[WIDTH-1:1]};
                    prodLoD = {alu_result[0], loQ[WIDTH-1:1]};
                    stateD  = DONE;
`endif
                end
            end
`ifdef SIGNED_MUL_EN
            FIX_LO: begin
                alu_data2 = loQ;
                alu_ctl   = negQ ? CTL_SUB : CTL_ADD;
                loD       = alu_result;
                loNzD     = (loQ != '0);
                stateD    = FIX_HI;
            end
            // Negating a 64-bit value: the high half borrows whenever the low half was non-zero.
            FIX_HI: begin
                alu_data2 = hiQ;
                alu_ctl   = negQ ? CTL_SUB : CTL_ADD;
                hiD       = alu_result - {{(WIDTH-1){1'b0}}, negQ & loNzQ};
                prodHiD   = alu_result - {{(WIDTH-1){1'b0}}, negQ & loNzQ};
                prodLoD   = loQ;
                stateD    = DONE;
            end
`endif
            DONE: begin
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    assign busy    = (stateQ != IDLE);
    assign done    = (stateQ == DONE);
    assign prod_hi = prodHiQ;
    assign prod_lo = prodLoQ;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: models the shared ALU and scores products through a queue.
// Build with SIGNED_MUL_EN defined to exercise the two's-complement variant.
module tb_alu_mul_sequencer;

    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
`ifdef SIGNED_MUL_EN
    localparam int LAT = 36;
`else
    localparam int LAT = 32;
`endif

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] mcand, mplier, aluResult, aluData1, aluData2, prodHi, prodLo;
    logic [3:0]  aluCtl;
    logic        busy, done;

    int errors = 0;
    int checks = 0;
    logic [63:0] expQ[$];

    always #5 clk = ~clk;

    // Stand-in for the shared EX-stage ALU
    assign aluResult = (aluCtl == CTL_SUB) ? (aluData1 - aluData2) : (aluData1 + aluData2);

    alu_mul_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
        .alu_result(aluResult), .alu_data1(aluData1), .alu_data2(aluData2),
        .alu_ctl(aluCtl), .busy(busy), .done(done), .prod_hi(prodHi), .prod_lo(prodLo)
    );

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
`ifdef SIGNED_MUL_EN
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
`else
        ea = {32'h0, a};
        eb = {32'h0, b};
`endif
        return ea * eb;
    endfunction

    // Drives one operation; cycles counts edges after the accepting edge until done is seen
    task automatic runOp(input logic [31:0] a, input logic [31:0] b, input bit holdStart,
                         output int cycles, output int busyCycles, output bit gotDone,
                         output logic [63:0] prod, output logic [3:0] firstCtl);
        @(negedge clk);
        mcand = a; mplier = b; start = 1'b1;
        @(posedge clk);
        cycles = 0; busyCycles = 0; gotDone = 1'b0; prod = '0; firstCtl = 4'hx;
        while (!gotDone && cycles < 200) begin
            @(negedge clk);
            if (cycles == 0) firstCtl = aluCtl;
            if (busy) busyCycles++;
            if (done) begin
                gotDone = 1'b1;
                prod = {prodHi, prodLo};
            end
            if (holdStart && !gotDone) begin
                mcand = $urandom; mplier = $urandom;
            end else begin
                start = 1'b0;
            end
            if (!gotDone) begin
                @(posedge clk);
                cycles++;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; mcand = 32'd9; mplier = 32'd9;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_flags busy/done=%b required 00", {busy, done});
        end
        checks++;
        if ({prodHi, prodLo} !== 64'h0) begin
            errors++; $display("[TB] FAIL reset_prod got %h required 0", {prodHi, prodLo});
        end
        checks++;
        if ({aluData1, aluData2, aluCtl} !== {64'h0, CTL_ADD}) begin
            errors++; $display("[TB] FAIL reset_alu got %h %h %h required 0 0 %h",
                               aluData1, aluData2, aluCtl, CTL_ADD);
        end
        reset = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("[TB] FAIL idle_after_reset busy=%b required 0", busy);
        end
    endtask

    task automatic test_op(input string name, input logic [31:0] a, input logic [31:0] b);
        int cyc, bcyc; bit got; logic [63:0] p, e; logic [3:0] c0;
        expQ.push_back(model(a, b));
        runOp(a, b, 1'b0, cyc, bcyc, got, p, c0);
        checks++;
        if (!got) begin
            errors++; $display("[TB] FAIL %s_timeout no done within 200 cycles", name);
            void'(expQ.pop_front());
        end else begin
            e = expQ.pop_front();
            if (p !== e) begin
                errors++; $display("[TB] FAIL %s_prod got %h required %h", name, p, e);
            end
            checks++;
            if (cyc != LAT) begin
                errors++; $display("[TB] FAIL %s_latency got %0d required %0d", name, cyc, LAT);
            end
            checks++;
            if (bcyc != LAT + 1) begin
                errors++; $display("[TB] FAIL %s_busy got %0d required %0d", name, bcyc, LAT + 1);
            end
`ifdef SIGNED_MUL_EN
            checks++;
            if (c0 !== (a[31] ? CTL_SUB : CTL_ADD)) begin
                errors++; $display("[TB] FAIL %s_abs_ctl got %h required %h", name, c0,
                                   a[31] ? CTL_SUB : CTL_ADD);
            end
`endif
        end
    endtask

    task automatic test_start_held;
        int cyc, bcyc, extra; bit got; logic [63:0] p, e; logic [3:0] c0;
        expQ.push_back(model(32'd1234, 32'd5678));
        runOp(32'd1234, 32'd5678, 1'b1, cyc, bcyc, got, p, c0);
        e = expQ.pop_front();
        checks++;
        if (!got || p !== e) begin
            errors++; $display("[TB] FAIL held_prod got %h (done=%b) required %h", p, got, e);
        end
        extra = 0;
        repeat (60) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++; $display("[TB] FAIL held_no_queue got %0d busy cycles required 0", extra);
        end
    endtask

    task automatic test_reset_midop;
        int cyc, bcyc, seen; bit got; logic [63:0] p, e; logic [3:0] c0;
        expQ.push_back(model(32'd77, 32'd99));
        @(negedge clk);
        mcand = 32'd77; mplier = 32'd99; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done} !== 2'b00 || {prodHi, prodLo} !== 64'h0) begin
            errors++; $display("[TB] FAIL abort_state busy/done=%b prod=%h required 00 and 0",
                               {busy, done}, {prodHi, prodLo});
        end
        checks++;
        if ({aluData1, aluData2, aluCtl} !== {64'h0, CTL_ADD}) begin
            errors++; $display("[TB] FAIL abort_alu got %h %h %h required 0 0 %h",
                               aluData1, aluData2, aluCtl, CTL_ADD);
        end
        @(negedge clk);
        reset = 1'b0;
        void'(expQ.pop_front());
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("[TB] FAIL abort_no_done got %0d pulses required 0", seen);
        end
        expQ.push_back(model(32'd6, 32'd7));
        runOp(32'd6, 32'd7, 1'b0, cyc, bcyc, got, p, c0);
        e = expQ.pop_front();
        checks++;
        if (!got || p !== e || cyc != LAT) begin
            errors++; $display("[TB] FAIL after_abort prod=%h lat=%0d done=%b required %h lat=%0d",
                               p, cyc, got, e, LAT);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, b;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom;
            test_op("random", a, b);
        end
    endtask

    initial begin
        test_reset;
        test_op("three_by_five", 32'd3, 32'd5);
        test_op("all_ones", 32'hFFFFFFFF, 32'hFFFFFFFF);
        test_op("zero", 32'h0, 32'h12345678);
        test_start_held;
        test_reset_midop;
        test_back_to_back;
`ifdef SIGNED_MUL_EN
        test_op("neg3_by_7", 32'hFFFFFFFD, 32'd7);
        test_op("minint_by_neg1", 32'h80000000, 32'hFFFFFFFF);
        test_op("7_by_neg3", 32'd7, 32'hFFFFFFFD);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
